// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared Morse code space, FSM states and element unit lengths
package morse_pkg;

    typedef enum logic [5:0] {
        ZERO = 6'd0, ONE, TWO, THREE, FOUR, FIVE, SIX, SEVEN, EIGHT, NINE,
        A, B, C, D, E, F, G, H, I, J, K, L, M,
        N, O, P, Q, R, S, T, U, V, W, X, Y, Z,
        N1, N2, N3, NULL
    } letter_t;

    typedef enum logic [2:0] {
        S_IDLE, S_MARK, S_SPACE, S_LGAP, S_WGAP, S_DONE
    } state_t;

    localparam logic [2:0] DOT_UNITS    = 3'd1;
    localparam logic [2:0] DASH_UNITS   = 3'd3;
    localparam logic [2:0] GAP_UNITS    = 3'd1;
    localparam logic [2:0] LETTER_UNITS = 3'd3;
    localparam logic [2:0] WORD_UNITS   = 3'd7;

    function automatic logic [2:0] element_units(input logic is_dash);
        return is_dash ? DASH_UNITS : DOT_UNITS;
    endfunction

endpackage

// File: rtl/morse_lut.sv
// rtl/morse_lut.sv - ITU Morse table: code -> element count and dash mask
module morse_lut
    import morse_pkg::*;
(
    input  logic [5:0] letter,
    output logic [2:0] len,
    output logic [4:0] pattern,
    output logic       valid,
    output logic       is_space
);

    logic [7:0] ent;

    // ent = {len, pattern}; pattern is read MSB-first from bit len-1, 1 = dash
    always_comb begin
        ent = 8'd0;
        case (letter)
            ZERO:  ent = {3'd5, 5'b11111};
            ONE:   ent = {3'd5, 5'b01111};
            TWO:   ent = {3'd5, 5'b00111};
            THREE: ent = {3'd5, 5'b00011};
            FOUR:  ent = {3'd5, 5'b00001};
            FIVE:  ent = {3'd5, 5'b00000};
            SIX:   ent = {3'd5, 5'b10000};
            SEVEN: ent = {3'd5, 5'b11000};
            EIGHT: ent = {3'd5, 5'b11100};
            NINE:  ent = {3'd5, 5'b11110};
            A:     ent = {3'd2, 5'b00001};
            B:     ent = {3'd4, 5'b01000};
            C:     ent = {3'd4, 5'b01010};
            D:     ent = {3'd3, 5'b00100};
            E:     ent = {3'd1, 5'b00000};
            F:     ent = {3'd4, 5'b00010};
            G:     ent = {3'd3, 5'b00110};
            H:     ent = {3'd4, 5'b00000};
            I:     ent = {3'd2, 5'b00000};
            J:     ent = {3'd4, 5'b00111};
            K:     ent = {3'd3, 5'b00101};
            L:     ent = {3'd4, 5'b00100};
            M:     ent = {3'd2, 5'b00011};
            N:     ent = {3'd2, 5'b00010};
            O:     ent = {3'd3, 5'b00111};
            P:     ent = {3'd4, 5'b00110};
            Q:     ent = {3'd4, 5'b01101};
            R:     ent = {3'd3, 5'b00010};
            S:     ent = {3'd3, 5'b00000};
            T:     ent = {3'd1, 5'b00001};
            U:     ent = {3'd3, 5'b00001};
            V:     ent = {3'd4, 5'b00001};
            W:     ent = {3'd3, 5'b00011};
            X:     ent = {3'd4, 5'b01001};
            Y:     ent = {3'd4, 5'b01011};
            Z:     ent = {3'd4, 5'b01100};
            default: ent = 8'd0;
        endcase
    end

    assign len      = ent[7:5];
    assign pattern  = ent[4:0];
    assign valid    = (ent[7:5] != 3'd0);
    assign is_space = (letter == NULL);

endmodule

// File: rtl/morse_encoder.sv
// rtl/morse_encoder.sv - keys one Morse character per handshake onto tone
module morse_encoder
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 10_000_000
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       newletter,
    input  logic [5:0] letter,
    output logic       tone,
    output logic       ready,
    output logic       done
);

    localparam int CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;

    state_t      state, nstate;
    logic [CW-1:0] cyc;
    logic [2:0]  units_left, idx, next_idx, load_units;
    logic [4:0]  pattern_q;
    logic        load, accept, cyc_term, unit_end, timing;

    logic [2:0]  lut_len;
    logic [4:0]  lut_pattern;
    logic        lut_valid, lut_space;

    morse_lut u_lut (
        .letter   (letter),
        .len      (lut_len),
        .pattern  (lut_pattern),
        .valid    (lut_valid),
        .is_space (lut_space)
    );

    assign accept   = (state == S_IDLE) && newletter;
    assign cyc_term = (cyc == CW'(UNIT_CYCLES - 1));
    assign unit_end = cyc_term && (units_left == 3'd0);
    assign timing   = (state == S_MARK) || (state == S_SPACE) ||
                      (state == S_LGAP) || (state == S_WGAP);
    assign done     = ((state == S_LGAP || state == S_WGAP) && unit_end) ||
                      (state == S_DONE);

    always_comb begin
        nstate     = state;
        load       = 1'b0;
        load_units = DOT_UNITS;
        next_idx   = idx;
        case (state)
            S_IDLE: begin
                if (newletter) begin
                    if (lut_space) begin
                        nstate     = S_WGAP;
                        load       = 1'b1;
                        load_units = WORD_UNITS;
                    end else if (lut_valid) begin
                        nstate     = S_MARK;
                        load       = 1'b1;
                        load_units = element_units(lut_pattern[lut_len - 3'd1]);
                        next_idx   = lut_len - 3'd1;
                    end else begin
                        nstate = S_DONE;
                    end
                end
            end
            S_MARK: begin
                if (unit_end) begin
                    load = 1'b1;
                    if (idx != 3'd0) begin
                        nstate     = S_SPACE;
                        load_units = GAP_UNITS;
                    end else begin
                        nstate     = S_LGAP;
                        load_units = LETTER_UNITS;
                    end
                end
            end
            S_SPACE: begin
                if (unit_end) begin
                    nstate     = S_MARK;
                    load       = 1'b1;
                    load_units = element_units(pattern_q[idx - 3'd1]);
                    next_idx   = idx - 3'd1;
                end
            end
            S_LGAP, S_WGAP: begin
                if (unit_end) nstate = S_IDLE;
            end
            S_DONE:  nstate = S_IDLE;
            default: nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            state      <= S_IDLE;
            cyc        <= '0;
            units_left <= 3'd0;
            idx        <= 3'd0;
            pattern_q  <= 5'd0;
            tone       <= 1'b0;
            ready      <= 1'b1;
        end else begin
            state <= nstate;
            tone  <= (nstate == S_MARK);
            ready <= (nstate == S_IDLE);
            idx   <= next_idx;
            if (accept) pattern_q <= lut_pattern;
            // a load restarts the unit timer; otherwise count cycles within the unit
            if (load) begin
                cyc        <= '0;
                units_left <= load_units - 3'd1;
            end else if (timing) begin
                if (cyc_term) begin
                    cyc <= '0;
                    if (units_left != 3'd0) units_left <= units_left - 3'd1;
                end else begin
                    cyc <= cyc + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_morse_encoder.sv
// tb/tb_morse_encoder.sv - directed self-checking bench for morse_encoder at 4 cycles/unit
module tb_morse_encoder;
    import morse_pkg::*;

    localparam int UC = 4;

    logic       clock = 1'b0;
    logic       clear;
    logic       newletter;
    logic [5:0] letter;
    logic       tone, ready, done;

    int tests = 0;
    int fails = 0;

    morse_encoder #(.UNIT_CYCLES(UC)) dut (
        .clock     (clock),
        .clear     (clear),
        .newletter (newletter),
        .letter    (letter),
        .tone      (tone),
        .ready     (ready),
        .done      (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        string      name;
        logic [5:0] code;
        int         nunits;
        logic [31:0] marks;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int c, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, c, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // accept code at edge 0, then check every cycle up to the first idle one
    task automatic run_vec(input vec_t v);
        int dcyc;
        dcyc = (v.nunits == 0) ? 1 : v.nunits * UC;
        newletter = 1'b1;
        letter    = v.code;
        step();
        newletter = 1'b0;
        for (int c = 1; c <= dcyc + 1; c++) begin
            if (c <= dcyc)
                chk({v.name, ".tone"}, c, tone, v.marks[(c - 1) / UC]);
            else
                chk({v.name, ".tone"}, c, tone, 1'b0);
            chk({v.name, ".done"}, c, done, c == dcyc);
            chk({v.name, ".ready"}, c, ready, c > dcyc);
            if (c <= dcyc) step();
        end
    endtask

    initial begin
        vecs[0] = '{"E",    E,          4,  32'h1};
        vecs[1] = '{"A",    A,          8,  32'h1D};
        vecs[2] = '{"ZERO", ZERO,       22, 32'h77777};
        vecs[3] = '{"NULL", NULL,       7,  32'h0};
        vecs[4] = '{"C40",  6'd40,      0,  32'h0};
        vecs[5] = '{"T",    T,          6,  32'h7};
        vecs[6] = '{"S",    S,          8,  32'h15};
        vecs[7] = '{"N1",   N1,         0,  32'h0};

        clear     = 1'b0;
        newletter = 1'b0;
        letter    = 6'd0;
        step();
        step();
        chk("reset.tone", 0, tone, 1'b0);
        chk("reset.done", 0, done, 1'b0);
        chk("reset.ready", 0, ready, 1'b1);
        clear = 1'b1;
        step();

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // requests while busy are dropped; T accepted once ready returns
        newletter = 1'b1;
        letter    = E;
        step();
        newletter = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            chk("busy.tone", c, tone, (c >= 1 && c <= 4) || (c >= 18 && c <= 29));
            chk("busy.done", c, done, c == 16 || c == 41);
            chk("busy.ready", c, ready, c == 17 || c >= 42);
            newletter = (c == 5 || c == 17);
            letter    = (c == 10) ? Z : T;
            step();
        end

        // clear during the dash of A aborts it without done
        newletter = 1'b1;
        letter    = A;
        step();
        newletter = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            chk("abort.tone", c, tone, (c <= 4) || (c >= 9 && c <= 10));
            chk("abort.done", c, done, 1'b0);
            chk("abort.ready", c, ready, c >= 11);
            clear     = !(c >= 10 && c <= 13);
            newletter = (c >= 10 && c <= 13);
            letter    = E;
            step();
        end
        newletter = 1'b0;
        run_vec(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/morse_encoder.md
# morse_encoder

Transmit-side counterpart to the Morse decoder/translator path. Accepts one 6-bit letter code per handshake, the same code space the decoder produces, and keys the ITU Morse pattern for that character on a single `tone` output (LED/buzzer). All element timing derives from one parameterised unit length. It sits between any character source (switches, test pattern ROM) and the board's tone/LED pin.

## Interface
- `UNIT_CYCLES`, default 10_000_000: clock cycles per Morse unit (dot length); legal ≥ 1.
- `clock` input, 1 bit: single clock, rising edge.
- `clear` input, 1 bit: reset, synchronous, active-low.
- `newletter` input, 1 bit: request strobe; accepted only when `ready`=1.
- `letter` input, 6 bits: character code, sampled only in the accept cycle.
- `tone` output, 1 bit: key output, 1 = mark.
- `ready` output, 1 bit: idle and able to accept.
- `done` output, 1 bit: one-cycle pulse on the final cycle of a character, including its trailing gap.

## Operation
- Code space:
  - 0–9 are digits ZERO..NINE.
  - 10–35 are A..Z.
  - 36–38 are N1..N3.
  - 39 is NULL.
  - 40–63 are undefined.
- Element timing, in units:
  - dot = 1 unit high.
  - dash = 3 units high.
  - intra-character gap = 1 unit low.
  - letter gap after the last element = 3 units low.
- NULL is a word space: 7 units low, no mark.
- N1..N3 and codes 40–63: accepted. `done` pulses in the cycle after accept; `tone` stays 0.
- Lookup gives `len` (1–5) and `pattern[4:0]`, where 1 = dash and elements are sent MSB-first from bit `len-1`.
- State machine:
  - IDLE (`ready`=1). On `newletter`=1: latch the lookup and go to MARK, or to WGAP for NULL, or to DONE for an invalid code.
  - MARK: `tone`=1 for 1 or 3 units. Then go to SPACE if elements remain, else LGAP.
  - SPACE: 1 unit low, then MARK with the next element.
  - LGAP: 3 units low. `done`=1 on its last cycle, then IDLE.
  - WGAP: 7 units low. `done`=1 on its last cycle, then IDLE.
  - DONE: a single cycle with `done`=1, then IDLE.
- Counters:
  - cycle counter 0..UNIT_CYCLES-1.
  - unit counter 0..7, 3 bits.
  - element index 0..4, 3 bits.
  - The cycle counter wraps and the unit counter decrements; the state advances when the unit counter is 0 and the cycle counter is at its terminal count.
- `newletter` while `ready`=0 is ignored, not queued; `letter` changes while busy have no effect.
- Reset values: `tone`=0, `done`=0, `ready`=1, state IDLE, all counters 0.
- `clear`=0 mid-character aborts it at the next edge: `tone` drops, no `done` is produced, and `newletter` is ignored while `clear`=0.

## Timing
- Accept at edge N (`newletter`=1 and `ready`=1). From N+1: `ready`=0, and `tone`=1 for the first mark.
- `tone` is registered; no combinational path from inputs to outputs.
- A character of T total units occupies cycles N+1 .. N+T·UNIT_CYCLES.
- `done` is high in cycle N+T·UNIT_CYCLES; `ready`=1 the cycle after.
- `ready`=0 during the `done` cycle, so back-to-back characters are separated by exactly the 3-unit letter gap plus one idle cycle.
- Invalid or N1–N3 codes: `done` at N+1, `ready` at N+2.
- UNIT_CYCLES=1 is legal; every unit is then one cycle.

## Structure
- Shared package `morse_pkg`, also used by the decoder/translator side:
  - letter code constants ZERO..Z, N1..N3, NULL.
  - state enum.
  - constants for dot/dash/gap/word units.
- Sub-module `morse_lut`: combinational, `letter[5:0]` → `len[2:0]`, `pattern[4:0]`, `valid`, `is_space`. Holds the full ITU table for 0–9 and A–Z.
- Top: FSM, counters, output registers.

## Test plan
All tests use UNIT_CYCLES=4 with accept at cycle 0.
- E: `tone`=1 on cycles 1–4, 0 on cycles 5–16. `done` at 16; `ready` at 17.
- A (.-):
  - tone 1–4 high, 5–8 low, 9–20 high, 21–32 low.
  - `done` at 32.
- ZERO (-----): 22 units, `done` at 88. Also check five 12-cycle marks separated by 4-cycle spaces.
- NULL: `tone` 0 throughout, `done` at 28. Code 40: `done` at 1, `ready` at 2, `tone` never 1.
- `newletter` pulsed with `letter`=T during an E transmission: ignored, E timing unchanged. Then T accepted at cycle 17 gives `tone` high 18–29.
- `clear`=0 at cycle 10 of A:
  - `tone`=0 and `ready`=1 from cycle 11.
  - no `done`.
  - a new E after release meets the E timing relative to its own accept.
